mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the write-back stage, and drives a single-port data memory through a req/ack handshake. It formats byte, halfword and word loads and stores, stalls the upstream pipeline while an access is outstanding, and owns the MEM/WB pipeline register that write-back consumes combinationally.

## Interface
Reset is asynchronous, active-high (`rst`); single clock `clk`.

Parameters:
- `TIMEOUT`, default 16: maximum cycles in ACCESS without `dmem_ack` before the access is aborted (range 1–255).

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: EX/MEM holds a real instruction.
- `Ctl_MemRead_in`, `Ctl_MemWrite_in`, `Ctl_RegWrite_in`, `Ctl_MemtoReg_in`, `jal_in`, `jalr_in` in 1 each: control from EX/MEM.
- `funct3_in` in 3: access size/sign.
- `PC_in` in 32, `ALUresult_in` in 32 (effective address), `Rs2Data_in` in 32 (store data), `Rd_in` in 5.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (bits [1:0] = 0), `dmem_be` out 4, `dmem_wdata` out 32: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32: memory response, valid in the ack cycle.
- `stall_out` out 1: hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `valid_out`, `Ctl_RegWrite_out`, `Ctl_MemtoReg_out`, `jal_out`, `jalr_out` out 1 each: MEM/WB register.
- `PC_out` out 32, `Rd_out` out 5, `ReadData_out` out 32 (extended), `ALUresult_out` out 32: MEM/WB register.
- `misalign_out`, `bus_err_out` out 1 each: one-cycle fault flags, aligned with the faulting instruction in MEM/WB.

## Operation
- Memory op = `valid_in & (Ctl_MemRead_in | Ctl_MemWrite_in)`. Read has priority if both are set.
- Misaligned access:
  - Condition: halfword (funct3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]≠0.
  - No request is issued.
  - The instruction enters MEM/WB with `misalign_out`=1 and `Ctl_RegWrite_out` forced to 0.
- FSM states: IDLE, ACCESS.
  - IDLE, aligned memory op: `stall_out`=1; capture address, be, wdata and we; go to ACCESS. MEM/WB loads a bubble.
  - IDLE, non-memory op: pass-through into MEM/WB at the next edge, `stall_out`=0.
  - ACCESS: `dmem_req`=1 with stable address, be, we and wdata; wait counter increments each cycle.
  - ACCESS with `dmem_ack`=1: `stall_out`=0; at the edge MEM/WB loads the instruction with extended `ReadData_out`; go to IDLE.
  - ACCESS with count = `TIMEOUT` and no ack: deassert `dmem_req`, load MEM/WB with `bus_err_out`=1 and `Ctl_RegWrite_out`=0, go to IDLE. An ack arriving after abort is ignored.
- Bubble: `valid_out`=0 and all control outputs 0; data fields don't-care (held).
- Loads: select the lane by addr[1:0].
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend halfword (lane addr[1]). LHU: zero-extend halfword.
  - LW: pass through.
  - Other funct3 values are treated as LW.
- Stores:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 << {addr[1],0}; wdata = halfword replicated ×2.
  - SW: be = 1111.
- Stores set `dmem_be`; loads drive `dmem_be`=1111.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0.
  - All outputs 0: `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `stall_out`, `valid_out`, all control outputs, PC/Rd/data outputs, fault flags.
  - Reset asserted mid-access drops `dmem_req` in the same cycle.
- Non-memory latency: 1 cycle (EX/MEM → MEM/WB).
- Memory op latency: 2 + N cycles, where N = wait cycles before ack. A zero-wait ack in the first ACCESS cycle gives 2 cycles.
- `stall_out` is combinational: it is high in the IDLE detect cycle and in every ACCESS cycle except the ack or timeout cycle.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered outputs.
- An ack seen in IDLE is ignored.
- Back-to-back memory ops: the second one is detected in IDLE on the cycle after the first completes, so there is no idle req gap beyond that one cycle.

## Structure
- Shared package/header `riscv_defs`:
  - funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state encodings.
  - `TIMEOUT` width.
- Sub-module `load_store_align`: combinational lane logic. Maps funct3, addr[1:0], store data and read data to be, wdata, extended load data and the misalign flag.
- Top level contains the FSM, wait counter, request registers and MEM/WB register.

## Test plan
- ALU op (`Ctl_RegWrite_in`=1, `ALUresult_in`=0x1234, Rd=5) → next cycle `valid_out`=1, `ALUresult_out`=0x1234, `Rd_out`=5, `stall_out` never asserted.
- LB, addr 0x103, memory word 0x80FF_0000, ack after 3 waits → `dmem_addr`=0x100; `stall_out` high 4 cycles; `ReadData_out`=0xFFFF_FF80.
- LHU, addr 0x102, rdata 0x8001_0000, zero-wait ack → `ReadData_out`=0x0000_8001; total latency 2 cycles.
- SB, addr 0x201, Rs2 0xAB → `dmem_be`=0010, `dmem_wdata`=0xABAB_ABAB, `dmem_we`=1. SW at addr 0x202 → no req, `misalign_out`=1, `Ctl_RegWrite_out`=0.
- LW, ack never arrives, `TIMEOUT`=16 → req deasserts after 16 ACCESS cycles, `bus_err_out`=1 for one cycle, `stall_out` drops; a late ack is ignored.
- Assert `rst` during ACCESS → `dmem_req`=0 and MEM/WB cleared immediately; after release, a fresh LW completes normally.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared encodings for the memory-access stage: funct3 sizes, FSM states and
// the registered data-memory request bundle.
package riscv_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int TIMEOUT_W = 8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store byte enables and replicated write data,
// load lane select with sign/zero extension, and the misalignment flag.
module load_store_align
  import riscv_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [3:0][7:0] rd_lanes;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  assign rd_lanes = read_data;
  assign lane_b   = rd_lanes[addr_lo];
  assign lane_h   = addr_lo[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    be    = 4'hF;
    wdata = store_data;
    case (funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH[1:0]: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      F3_SW[1:0]: begin
        be    = 4'hF;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  // Unlisted funct3 encodings fall back to a full-word load.
  always_comb begin
    load_data = read_data;
    case (funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  load_data = {24'h0, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  load_data = {16'h0, lane_h};
      F3_LW:   load_data = read_data;
      default: ;
    endcase
  end

  assign misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: issues data-memory accesses over req/ack, stalls upstream
// while an access is outstanding, and owns the MEM/WB pipeline register.
module mem_stage
  import riscv_defs::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemtoReg_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] Rs2Data_in,
  input  logic [4:0]  Rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        valid_out,
  output logic        Ctl_RegWrite_out,
  output logic        Ctl_MemtoReg_out,
  output logic        jal_out,
  output logic        jalr_out,
  output logic [31:0] PC_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  state_t                 state;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  dmem_req_t              req_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_data;
  logic        misalign;
  logic        mem_op, go_access, mis_fault, ack_hit, timed_out, wb_load;

  load_store_align u_align (
    .funct3     (funct3_in),
    .addr_lo    (ALUresult_in[1:0]),
    .store_data (Rs2Data_in),
    .read_data  (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  assign mem_op    = valid_in & (Ctl_MemRead_in | Ctl_MemWrite_in);
  assign go_access = (state == S_IDLE) & mem_op & ~misalign;
  assign mis_fault = (state == S_IDLE) & mem_op & misalign;
  assign ack_hit   = (state == S_ACCESS) & dmem_ack;
  assign timed_out = (state == S_ACCESS) & ~dmem_ack &
                     (wait_cnt == TIMEOUT_W'(TIMEOUT));
  // EX/MEM is held during ACCESS, so the completing cycle still sees the instruction.
  assign wb_load   = ((state == S_IDLE) & ~go_access) | ack_hit | timed_out;
  assign stall_out = ~rst & (go_access | ((state == S_ACCESS) & ~ack_hit & ~timed_out));

  assign dmem_req   = req_q.req;
  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_be    = req_q.be;
  assign dmem_wdata = req_q.wdata;

  // wait_cnt is 1 in the first ACCESS cycle, so TIMEOUT counts ACCESS cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      req_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_access) begin
            state       <= S_ACCESS;
            wait_cnt    <= TIMEOUT_W'(1);
            req_q.req   <= 1'b1;
            req_q.we    <= ~Ctl_MemRead_in;
            req_q.addr  <= {ALUresult_in[31:2], 2'b00};
            req_q.be    <= Ctl_MemRead_in ? 4'hF : be_c;
            req_q.wdata <= wdata_c;
          end
        end
        S_ACCESS: begin
          if (ack_hit || timed_out) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            req_q.req <= 1'b0;
            req_q.we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out        <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Ctl_MemtoReg_out <= 1'b0;
      jal_out          <= 1'b0;
      jalr_out         <= 1'b0;
      PC_out           <= '0;
      Rd_out           <= '0;
      ReadData_out     <= '0;
      ALUresult_out    <= '0;
      misalign_out     <= 1'b0;
      bus_err_out      <= 1'b0;
    end else if (wb_load && valid_in) begin
      valid_out        <= 1'b1;
      Ctl_RegWrite_out <= Ctl_RegWrite_in & ~mis_fault & ~timed_out;
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
      jal_out          <= jal_in;
      jalr_out         <= jalr_in;
      PC_out           <= PC_in;
      Rd_out           <= Rd_in;
      ALUresult_out    <= ALUresult_in;
      if (ack_hit) ReadData_out <= load_data;
      misalign_out     <= mis_fault;
      bus_err_out      <= timed_out;
    end else begin
      valid_out        <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Ctl_MemtoReg_out <= 1'b0;
      jal_out          <= 1'b0;
      jalr_out         <= 1'b0;
      misalign_out     <= 1'b0;
      bus_err_out      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads with waits, stores,
// misalignment, timeout abort and reset during an access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_RegWrite_in, Ctl_MemtoReg_in;
  logic        jal_in, jalr_in;
  logic [2:0]  funct3_in;
  logic [31:0] PC_in, ALUresult_in, Rs2Data_in;
  logic [4:0]  Rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_out, valid_out, Ctl_RegWrite_out, Ctl_MemtoReg_out, jal_out, jalr_out;
  logic [31:0] PC_out, ReadData_out, ALUresult_out;
  logic [4:0]  Rd_out;
  logic        misalign_out, bus_err_out;

  int total = 0;
  int fails = 0;
  int sc;
  int acc;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
    .Ctl_RegWrite_in(Ctl_RegWrite_in), .Ctl_MemtoReg_in(Ctl_MemtoReg_in),
    .jal_in(jal_in), .jalr_in(jalr_in), .funct3_in(funct3_in),
    .PC_in(PC_in), .ALUresult_in(ALUresult_in), .Rs2Data_in(Rs2Data_in), .Rd_in(Rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .valid_out(valid_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
    .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .jal_out(jal_out), .jalr_out(jalr_out),
    .PC_out(PC_out), .Rd_out(Rd_out), .ReadData_out(ReadData_out),
    .ALUresult_out(ALUresult_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rd, input logic wr, input logic rw, input logic m2r,
                           input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] rs2, input logic [4:0] rdn);
    valid_in        = 1'b1;
    Ctl_MemRead_in  = rd;
    Ctl_MemWrite_in = wr;
    Ctl_RegWrite_in = rw;
    Ctl_MemtoReg_in = m2r;
    jal_in          = 1'b0;
    jalr_in         = 1'b0;
    funct3_in       = f3;
    PC_in           = pc;
    ALUresult_in    = alu;
    Rs2Data_in      = rs2;
    Rd_in           = rdn;
  endtask

  task automatic clear_instr();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    valid_in = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    // A load is presented during reset: stall must still be held low.
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h500, 32'h0, 5'd3);
    tick();
    chk("rst_req",   32'(dmem_req),     32'h0);
    chk("rst_be",    32'(dmem_be),      32'h0);
    chk("rst_addr",  dmem_addr,         32'h0);
    chk("rst_valid", 32'(valid_out),    32'h0);
    chk("rst_rdata", ReadData_out,      32'h0);
    chk("rst_stall", 32'(stall_out),    32'h0);
    rst = 1'b0;
    clear_instr();

    // ALU op pass-through
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h1234, 32'h0, 5'd5);
    jal_in = 1'b1;
    #1;
    chk("alu_stall", 32'(stall_out), 32'h0);
    tick();
    chk("alu_valid", 32'(valid_out),        32'h1);
    chk("alu_res",   ALUresult_out,         32'h1234);
    chk("alu_rd",    32'(Rd_out),           32'h5);
    chk("alu_rw",    32'(Ctl_RegWrite_out), 32'h1);
    chk("alu_pc",    PC_out,                32'h40);
    chk("alu_jal",   32'(jal_out),          32'h1);
    clear_instr();
    tick();
    chk("bubble_valid", 32'(valid_out),        32'h0);
    chk("bubble_rw",    32'(Ctl_RegWrite_out), 32'h0);

    // LB at 0x103, three wait cycles then ack
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h44, 32'h103, 32'h0, 5'd7);
    #1;
    sc = int'(stall_out);
    tick();
    chk("lb_req",  32'(dmem_req),  32'h1);
    chk("lb_addr", dmem_addr,      32'h100);
    chk("lb_be",   32'(dmem_be),   32'hF);
    chk("lb_we",   32'(dmem_we),   32'h0);
    chk("lb_wait_valid", 32'(valid_out), 32'h0);
    sc += int'(stall_out);
    tick();
    sc += int'(stall_out);
    tick();
    sc += int'(stall_out);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    #1;
    chk("lb_ack_stall", 32'(stall_out), 32'h0);
    chk("lb_stall_cycles", 32'(sc), 32'd4);
    tick();
    dmem_ack = 1'b0;
    clear_instr();
    chk("lb_valid",  32'(valid_out),        32'h1);
    chk("lb_data",   ReadData_out,          32'hFFFF_FF80);
    chk("lb_rd",     32'(Rd_out),           32'h7);
    chk("lb_rw",     32'(Ctl_RegWrite_out), 32'h1);
    chk("lb_m2r",    32'(Ctl_MemtoReg_out), 32'h1);
    chk("lb_req_dn", 32'(dmem_req),         32'h0);

    // LHU at 0x102, zero-wait ack: valid two edges after presentation
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h48, 32'h102, 32'h0, 5'd8);
    #1;
    chk("lhu_stall", 32'(stall_out), 32'h1);
    tick();
    chk("lhu_valid_early", 32'(valid_out), 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h8001_0000;
    #1;
    chk("lhu_ack_stall", 32'(stall_out), 32'h0);
    tick();
    dmem_ack = 1'b0;
    clear_instr();
    chk("lhu_valid", 32'(valid_out), 32'h1);
    chk("lhu_data",  ReadData_out,   32'h0000_8001);

    // SB at 0x201, then misaligned SW at 0x202
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h4C, 32'h201, 32'h1234_56AB, 5'd0);
    tick();
    chk("sb_be",    32'(dmem_be),  32'h2);
    chk("sb_wdata", dmem_wdata,    32'hABAB_ABAB);
    chk("sb_we",    32'(dmem_we),  32'h1);
    chk("sb_addr",  dmem_addr,     32'h200);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sb_valid", 32'(valid_out), 32'h1);
    set_instr(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h50, 32'h202, 32'hCAFE_F00D, 5'd9);
    #1;
    chk("sw_mis_stall", 32'(stall_out), 32'h0);
    tick();
    clear_instr();
    chk("sw_mis_req",   32'(dmem_req),         32'h0);
    chk("sw_mis_flag",  32'(misalign_out),     32'h1);
    chk("sw_mis_rw",    32'(Ctl_RegWrite_out), 32'h0);
    chk("sw_mis_valid", 32'(valid_out),        32'h1);
    tick();
    chk("sw_mis_flag_clr", 32'(misalign_out), 32'h0);

    // LW with no ack: abort after 16 ACCESS cycles
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h54, 32'h300, 32'h0, 5'd10);
    tick();
    acc = 0;
    for (int i = 0; i < 40 && dmem_req === 1'b1 && stall_out === 1'b1; i++) begin
      acc++;
      tick();
    end
    chk("to_stall_cycles", 32'(acc),      32'd15);
    chk("to_last_req",     32'(dmem_req), 32'h1);
    tick();
    chk("to_req_dn", 32'(dmem_req),         32'h0);
    chk("to_berr",   32'(bus_err_out),      32'h1);
    chk("to_valid",  32'(valid_out),        32'h1);
    chk("to_rw",     32'(Ctl_RegWrite_out), 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    clear_instr();
    #1;
    chk("to_late_stall", 32'(stall_out), 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("to_berr_clr",  32'(bus_err_out), 32'h0);
    chk("to_late_req",  32'(dmem_req),    32'h0);
    chk("to_late_vld",  32'(valid_out),   32'h0);

    // Reset in the middle of an access, then a fresh LW
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h58, 32'h400, 32'h0, 5'd9);
    tick();
    chk("ra_req", 32'(dmem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ra_req_dn", 32'(dmem_req),  32'h0);
    chk("ra_addr",   dmem_addr,      32'h0);
    chk("ra_stall",  32'(stall_out), 32'h0);
    chk("ra_valid",  32'(valid_out), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("ra_detect_stall", 32'(stall_out), 32'h1);
    tick();
    chk("ra2_req",  32'(dmem_req), 32'h1);
    chk("ra2_addr", dmem_addr,     32'h400);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    clear_instr();
    chk("ra2_valid", 32'(valid_out),  32'h1);
    chk("ra2_data",  ReadData_out,    32'hDEAD_BEEF);
    chk("ra2_rd",    32'(Rd_out),     32'h9);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
